// File: rtl/ntt_stream_io.sv
// ntt_stream_io
//   Streaming front/back end for the NTT core. Loads one polynomial of N = 2^RING_DEPTH
//   coefficients from a valid/ready stream into 2*PE_NUMBER data-memory banks, kicks the
//   address generator, waits for it to finish, then reads the result region back row by
//   row and serializes it onto a valid/ready output stream in raw storage order.
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   go                      1-cycle request to start a transform (honoured only when idle)
//   busy, done              busy outside IDLE; done pulses after the last output word
//   din_valid/ready/data    input coefficient stream
//   dout_valid/ready/data   output coefficient stream
//   mem_own                 1 = this block drives the data-memory ports
//   mwen/mwaddr/mwdata      one-hot bank write strobe, {region, row} address, broadcast data
//   mraddr/mrdata           common read address, all banks' read data (bank b at b*DATA_SIZE)
//   ntt_start/ntt_finished  handshake with the address generator
module ntt_stream_io #(
  parameter int unsigned RING_DEPTH = 12,
  parameter int unsigned PE_DEPTH   = 3,
  parameter int unsigned DATA_SIZE  = 60,
  parameter int unsigned RD_LAT     = 2,
  localparam int unsigned B         = 1 << (PE_DEPTH + 1),
  localparam int unsigned AW        = RING_DEPTH - PE_DEPTH + 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   go,
  output logic                   busy,
  output logic                   done,
  input  logic                   din_valid,
  output logic                   din_ready,
  input  logic [DATA_SIZE-1:0]   din_data,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic [DATA_SIZE-1:0]   dout_data,
  output logic                   mem_own,
  output logic [B-1:0]           mwen,
  output logic [AW-1:0]          mwaddr,
  output logic [DATA_SIZE-1:0]   mwdata,
  output logic [AW-1:0]          mraddr,
  input  logic [B*DATA_SIZE-1:0] mrdata,
  output logic                   ntt_start,
  input  logic                   ntt_finished
);

  localparam int unsigned N  = 1 << RING_DEPTH;
  localparam int unsigned R  = N / B;
  localparam int unsigned RW = RING_DEPTH - PE_DEPTH - 1;
  // Wait counter only has to reach RD_LAT-1.
  localparam int unsigned WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [RING_DEPTH:0] KLast    = (RING_DEPTH + 1)'(N - 1);
  localparam logic [RW-1:0]       RowLast  = RW'(R - 1);
  localparam logic [PE_DEPTH:0]   LaneLast = (PE_DEPTH + 1)'(B - 1);
  localparam logic [WW-1:0]       WaitLast = WW'(RD_LAT - 1);

  typedef enum logic [2:0] {
    StIdle, StLoad, StKick, StRun, StRdReq, StRdWait, StSend
  } state_e;

  state_e                 r_state, w_state_d;
  logic [RING_DEPTH:0]    r_k;
  logic [RW-1:0]          r_row;
  logic [PE_DEPTH:0]      r_lane;
  logic [WW-1:0]          r_wait;
  logic [B*DATA_SIZE-1:0] r_rowbuf;
  logic                   r_done;

  logic w_in_hs;
  logic w_out_hs;
  logic w_row_end;

  assign w_in_hs   = (r_state == StLoad) && din_valid;
  assign w_out_hs  = (r_state == StSend) && dout_ready;
  assign w_row_end = w_out_hs && (r_lane == LaneLast);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic; go and ntt_finished are only looked at in IDLE and RUN respectively.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:   if (go) w_state_d = StLoad;
      StLoad:   if (w_in_hs && (r_k == KLast)) w_state_d = StKick;
      StKick:   w_state_d = StRun;
      StRun:    if (ntt_finished) w_state_d = StRdReq;
      StRdReq:  w_state_d = StRdWait;
      StRdWait: if (r_wait == WaitLast) w_state_d = StSend;
      StSend:   if (w_row_end) w_state_d = (r_row == RowLast) ? StIdle : StRdReq;
      default:  w_state_d = StIdle;
    endcase
  end

  // Outputs; memory write strobes are combinational so the write lands with the accept.
  always_comb begin
    busy       = (r_state != StIdle);
    din_ready  = 1'b0;
    dout_valid = 1'b0;
    ntt_start  = 1'b0;
    mem_own    = 1'b1;
    mwen       = '0;
    mwaddr     = '0;
    mraddr     = '0;
    mwdata     = din_data;
    dout_data  = r_rowbuf[r_lane * DATA_SIZE +: DATA_SIZE];
    case (r_state)
      StLoad: begin
        din_ready = 1'b1;
        if (w_in_hs) begin
          mwen   = B'(1) << r_k[PE_DEPTH:0];
          mwaddr = {2'b00, r_k[RING_DEPTH:PE_DEPTH+1]};
        end
      end
      StKick: begin
        ntt_start = 1'b1;
        mem_own   = 1'b0;
      end
      StRun:   mem_own = 1'b0;
      StRdReq: mraddr = {2'b10, 1'b0, r_row};
      StSend:  dout_valid = 1'b1;
      default: ;
    endcase
  end

  // Counters, row buffer and done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_k      <= '0;
      r_row    <= '0;
      r_lane   <= '0;
      r_wait   <= '0;
      r_rowbuf <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_row_end && (r_row == RowLast);
      case (r_state)
        StIdle: r_k <= '0;
        StLoad: if (w_in_hs) r_k <= r_k + 1'b1;
        StRun:  r_row <= '0;
        StRdReq: r_wait <= '0;
        StRdWait: begin
          r_wait <= r_wait + 1'b1;
          // Read data for the address driven in RDREQ is present RD_LAT cycles later.
          if (r_wait == WaitLast) begin
            r_rowbuf <= mrdata;
            r_lane   <= '0;
          end
        end
        StSend: begin
          if (w_out_hs && (r_lane != LaneLast)) r_lane <= r_lane + 1'b1;
          if (w_row_end && (r_row != RowLast)) r_row <= r_row + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign done = r_done;

endmodule

// File: tb/tb_ntt_stream_io.sv
// tb_ntt_stream_io
//   Self-checking bench for ntt_stream_io (N = 32, B = 4, R = 8, RD_LAT = 2). A memory model
//   with a 2-cycle read pipeline and an NTT stub sit around the DUT. The stub raises
//   ntt_finished 40 cycles after ntt_start and fills region 2 either with 1000 + k or with
//   3*x + 7 of the loaded region-0 contents. The expected output stream is computed from the
//   input coefficient list alone: word k of the output must be the transform of input word k.
module tb_ntt_stream_io;
  localparam int N  = 32;
  localparam int B  = 4;
  localparam int R  = 8;
  localparam int DS = 16;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          go_main = 1'b0;
  logic          go_send = 1'b0;
  logic          go;
  logic          busy, done;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic [DS-1:0] din_data = '0;
  logic          dout_valid;
  logic          dout_ready = 1'b0;
  logic [DS-1:0] dout_data;
  logic          mem_own;
  logic [B-1:0]  mwen;
  logic [AW-1:0] mwaddr, mraddr;
  logic [DS-1:0] mwdata;
  logic [B*DS-1:0] mrdata;
  logic          ntt_start, ntt_finished;
  logic          spur_fin = 1'b0;

  assign go = go_main | go_send;

  ntt_stream_io #(
    .RING_DEPTH(5), .PE_DEPTH(1), .DATA_SIZE(DS), .RD_LAT(2)
  ) u_dut (
    .clk(clk), .reset(reset), .go(go), .busy(busy), .done(done),
    .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .mem_own(mem_own), .mwen(mwen), .mwaddr(mwaddr), .mwdata(mwdata),
    .mraddr(mraddr), .mrdata(mrdata), .ntt_start(ntt_start), .ntt_finished(ntt_finished)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- memory model + NTT stub ----------------
  logic [DS-1:0] mem [0:3][0:15][0:B-1];
  logic [AW-1:0] rd1 = '0, rd2 = '0;
  int ntt_cnt = 0;
  int stub_mode = 0;

  assign ntt_finished = (ntt_cnt == 1) || spur_fin;

  always @(posedge clk) begin
    rd1 <= mraddr;
    rd2 <= rd1;
    if (mem_own)
      for (int b = 0; b < B; b++)
        if (mwen[b]) mem[mwaddr[5:4]][mwaddr[3:0]][b] <= mwdata;
    if (ntt_start) ntt_cnt <= 40;
    else if (ntt_cnt > 0) ntt_cnt <= ntt_cnt - 1;
    if (ntt_cnt == 1)
      for (int r = 0; r < R; r++)
        for (int b = 0; b < B; b++)
          mem[2][r][b] <= (stub_mode == 0) ? DS'(1000 + r * B + b) : DS'(mem[0][r][b] * 3 + 7);
  end

  for (genvar b = 0; b < B; b++) begin : g_rd
    assign mrdata[b*DS +: DS] = mem[rd2[5:4]][rd2[3:0]][b];
  end

  // ---------------- reference model state ----------------
  logic [DS-1:0] coef [N];
  logic [DS-1:0] exp_arr [N];
  int rdy_pct = 100;
  bit spur_send = 1'b0;

  // Output-side driver: random dout_ready, optional stray go while words are being sent.
  initial forever begin
    @(posedge clk);
    #1;
    dout_ready = ($urandom_range(0, 99) < rdy_pct);
    go_send    = spur_send && dout_valid && ($urandom_range(0, 1) == 1);
  end

  // ---------------- compare process ----------------
  int out_idx = 0, wr_cnt = 0, start_cnt = 0, done_cnt = 0;
  int last_in_cyc = -10, last_out_cyc = -10, done_cyc = 0;
  int first_word = -1, last_word = -1;
  bit prev_stall = 1'b0;
  logic [DS-1:0] prev_data = '0;

  initial forever begin
    @(negedge clk);
    if (reset) begin
      out_idx    = 0;
      prev_stall = 1'b0;
    end else begin
      if (go && !busy) out_idx = 0;
      check("wen_iff_accept", longint'(mwen != 0), longint'(din_valid && din_ready));
      if (mwen != 0) begin
        wr_cnt++;
        check("wen_onehot", longint'($onehot(mwen)), 1);
      end
      if (din_ready || dout_valid) check("own_when_streaming", mem_own, 1);
      if (din_ready || dout_valid || !mem_own) check("busy_when_active", busy, 1);
      if (ntt_start) begin
        start_cnt++;
        check("start_latency", cyc, last_in_cyc + 1);
        check("own_drop_at_kick", mem_own, 0);
      end
      if (ntt_finished && ntt_cnt == 1) check("own_low_in_run", mem_own, 0);
      if (din_valid && din_ready) last_in_cyc = cyc;
      if (prev_stall) begin
        check("dout_hold_valid", dout_valid, 1);
        check("dout_hold_data", dout_data, prev_data);
      end
      if (dout_valid && dout_ready) begin
        if (out_idx < N) begin
          check("dout_word", dout_data, exp_arr[out_idx]);
          if (out_idx == 0) first_word = int'(dout_data);
          if (out_idx == N - 1) last_word = int'(dout_data);
        end else begin
          check("dout_extra_word", out_idx, N - 1);
        end
        out_idx++;
        last_out_cyc = cyc;
      end
      prev_stall = dout_valid && !dout_ready;
      prev_data  = dout_data;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_latency", cyc, last_out_cyc + 1);
        check("busy_low_at_done", busy, 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_din_ready"}, din_ready, 0);
    check({tag, "_dout_valid"}, dout_valid, 0);
    check({tag, "_ntt_start"}, ntt_start, 0);
    check({tag, "_mwen"}, mwen, 0);
    check({tag, "_mwaddr"}, mwaddr, 0);
    check({tag, "_mraddr"}, mraddr, 0);
    check({tag, "_mem_own"}, mem_own, 1);
  endtask

  task automatic do_load(input int mode, input int vpct, input bit spur, output int g);
    int i = 0;
    int guard = 0;
    bit hs;
    for (int k = 0; k < N; k++) begin
      coef[k]    = (mode == 0) ? DS'(k) : DS'($urandom_range(0, 65535));
      exp_arr[k] = (mode == 0) ? DS'(1000 + k) : DS'(coef[k] * 3 + 7);
    end
    stub_mode = mode;
    @(posedge clk);
    #1;
    go_main = 1'b1;
    g = cyc;
    @(posedge clk);
    #1;
    go_main = 1'b0;
    while (i < N && guard < 2000) begin
      din_valid = ($urandom_range(0, 99) < vpct);
      din_data  = coef[i];
      if (spur) begin
        go_main  = ($urandom_range(0, 1) == 1);
        spur_fin = ($urandom_range(0, 1) == 1);
      end
      @(negedge clk);
      hs = din_valid && din_ready;
      @(posedge clk);
      #1;
      if (hs) i++;
      guard++;
    end
    din_valid = 1'b0;
    go_main   = 1'b0;
    spur_fin  = spur;  // lands on the KICK cycle
    @(posedge clk);
    #1;
    spur_fin = 1'b0;
    if (i < N) check("load_accepts_within_budget", i, N);
  endtask

  task automatic wait_done(input int d0);
    int guard = 0;
    while (done_cnt == d0 && guard < 3000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (done_cnt == d0) check("done_within_budget", done_cnt, d0 + 1);
  endtask

  task automatic transform(input int mode, input int vpct, input int rpct, input bit spur,
                           input int exp_cycles);
    int s0 = start_cnt;
    int w0 = wr_cnt;
    int d0 = done_cnt;
    int g;
    rdy_pct   = rpct;
    spur_send = spur;
    do_load(mode, vpct, spur, g);
    wait_done(d0);
    spur_send = 1'b0;
    rdy_pct   = 100;
    repeat (3) @(posedge clk);
    #1;
    check("strobes_per_run", wr_cnt - w0, N);
    check("start_pulses", start_cnt - s0, 1);
    check("done_pulses", done_cnt - d0, 1);
    check("words_out", out_idx, N);
    if (exp_cycles > 0) check("go_to_done_cycles", done_cyc - g, exp_cycles);
  endtask

  initial begin
    @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(posedge clk);
    #2;
    reset = 1'b0;

    // Clean run: load 0..31, stub returns 1000 + k. go->done = 1 + 32 + 1 + 40 + 8*7 = 130.
    transform(0, 100, 100, 1'b0, 130);
    check("bank2_row3_literal", mem[0][3][2], 14);
    for (int k = 0; k < N; k++) check("load_map", mem[0][k / B][k % B], k);
    check("first_word_literal", first_word, 1000);
    check("last_word_literal", last_word, 1031);

    // Backpressure on both streams, same output sequence expected.
    transform(0, 50, 30, 1'b0, 0);
    check("bp_last_word_literal", last_word, 1031);
    // Backpressure with random data flowing end to end.
    transform(1, 50, 30, 1'b0, 0);

    // Stray go in LOAD/SEND, stray ntt_finished in LOAD and on the KICK cycle.
    transform(1, 100, 100, 1'b1, 130);

    // Reset after 20 output words, then a clean full run.
    rdy_pct = 100;
    begin
      int g;
      int guard = 0;
      do_load(1, 100, 1'b0, g);
      while (out_idx < 20 && guard < 500) begin
        @(posedge clk);
        guard++;
      end
      check("reached_20_words", longint'(out_idx >= 20), 1);
      #2;
      reset = 1'b1;
      #1;
      check_reset_outputs("midreset");
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
    end
    transform(1, 100, 100, 1'b0, 130);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
